// File: rtl/ut_serial_pkg.sv
// ut_serial_pkg: shared state encoding, mode constants and byte transform for the UART unit-test engine
package ut_serial_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RX, S_STAT, S_TX} state_t;
    localparam int MODE_ECHO = 0;
    localparam int MODE_UPPER = 1;
    localparam int MODE_SWAP = 2;
    localparam int DEF_REG_DATA = 0;
    localparam int DEF_REG_STAT = 1;
    localparam int DEF_TXRDY_BIT = 1;
    function automatic logic [7:0] xform(input logic [7:0] b, input int mode);
        logic lower, upper;
        lower = b >= 8'h61 && b <= 8'h7A;
        upper = b >= 8'h41 && b <= 8'h5A;
        return (mode != MODE_ECHO && lower) ? b - 8'h20 :
               (mode == MODE_SWAP && upper) ? b + 8'h20 : b;
    endfunction
endpackage

// File: rtl/fsm_ut_serial_fifo_fifo.sv
// fsm_ut_fifo: synchronous FIFO with naturally wrapping pointers and a registered occupancy count
module fsm_ut_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              wb_clk_i,
    input  logic              rst_n_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    localparam logic [AW:0] ONE = 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign dout = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop) rd_ptr <= rd_ptr + ONE;
            level <= level + (do_push ? ONE : '0) - (do_pop ? ONE : '0);
        end
    end
    // Storage carries no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fsm_ut_serial_fifo.sv
// fsm_ut_serial_fifo: wishbone master that buffers UART RX bytes and drains them back to TX after polling TX-ready
module fsm_ut_serial_fifo
    import ut_serial_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH = 8,
    parameter int MODE = MODE_ECHO,
    parameter int ACK_TMO = 15,
    parameter int REG_DATA = DEF_REG_DATA,
    parameter int REG_STAT = DEF_REG_STAT,
    parameter int TXRDY_BIT = DEF_TXRDY_BIT,
    localparam int AW = $clog2(DEPTH),
    localparam int TW = $clog2(ACK_TMO + 1)
) (
    input  logic              wb_clk_i,
    input  logic              rst_n_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_datw_o,
    input  logic [DATA_W-1:0] wb_datr_i,
    input  logic              wb_ack_i,
    input  logic              int_i,
    output logic [AW:0]       fifo_lvl_o,
    output logic [7:0]        drop_cnt_o,
    output logic [7:0]        tmo_cnt_o,
    output logic              busy_o
);
    state_t state;
    logic [TW-1:0] tmo_q;
    logic tx_ok;
    logic push, pop, full, empty;
    logic [DATA_W-1:0] push_d, fifo_head;
    assign wb_stb_o = wb_cyc_o;
    assign push = state == S_RX && wb_ack_i;
    assign pop = state == S_TX && wb_ack_i;
    always_comb begin
        push_d = wb_datr_i;
        push_d[7:0] = xform(wb_datr_i[7:0], MODE);
    end
    fsm_ut_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .wb_clk_i(wb_clk_i),
        .rst_n_i(rst_n_i),
        .push(push),
        .pop(pop),
        .din(push_d),
        .dout(fifo_head),
        .full(full),
        .empty(empty),
        .level(fifo_lvl_o)
    );
    // tx_ok remembers a TX-ready poll so a pending RX can be served before the write.
    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            busy_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o <= 1'b0;
            wb_addr_o <= '0;
            wb_datw_o <= '0;
            tmo_q <= '0;
            tx_ok <= 1'b0;
            drop_cnt_o <= '0;
            tmo_cnt_o <= '0;
        end else if (state == S_IDLE) begin
            tmo_q <= '0;
            if (int_i) begin
                state <= S_RX;
                busy_o <= 1'b1;
                wb_cyc_o <= 1'b1;
                wb_we_o <= 1'b0;
                wb_addr_o <= ADDR_W'(REG_DATA);
            end else if (tx_ok && !empty) begin
                state <= S_TX;
                busy_o <= 1'b1;
                wb_cyc_o <= 1'b1;
                wb_we_o <= 1'b1;
                wb_addr_o <= ADDR_W'(REG_DATA);
                wb_datw_o <= fifo_head;
                tx_ok <= 1'b0;
            end else if (!empty) begin
                state <= S_STAT;
                busy_o <= 1'b1;
                wb_cyc_o <= 1'b1;
                wb_we_o <= 1'b0;
                wb_addr_o <= ADDR_W'(REG_STAT);
            end
        end else if (wb_ack_i) begin
            state <= S_IDLE;
            busy_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o <= 1'b0;
            if (state == S_RX && full) drop_cnt_o <= drop_cnt_o + 8'(drop_cnt_o != 8'hFF);
            if (state == S_STAT) tx_ok <= wb_datr_i[TXRDY_BIT];
        end else if (tmo_q == TW'(ACK_TMO - 1)) begin
            state <= S_IDLE;
            busy_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o <= 1'b0;
            tmo_cnt_o <= tmo_cnt_o + 8'(tmo_cnt_o != 8'hFF);
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
endmodule
